pc_sequencer: RTL and testbench

Program-counter control unit for the 16-bit processor core. Holds the architectural PC and selects the next fetch address each cycle from sequential increment (+2), jump, taken branch, interrupt vector or interrupt return. Presents the PC to instruction memory through a valid/ready fetch handshake, and holds it on pipeline stall or halt. It owns PC sequencing; it does not decode instructions.

---
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter control for the 16-bit core.
// Holds the architectural PC and picks the next fetch address each cycle from
// sequential step, jump, taken branch, interrupt vector or interrupt return.
// The PC is presented to instruction memory through a valid/ready handshake.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-high reset
//   stall, fetch_ready             gate sequential advance only
//   jump/jump_target               unconditional redirect
//   branch_taken/branch_target     taken-branch redirect
//   reti                           return from interrupt (pc<=epc, irq_en<=1)
//   halt                           enter HALT
//   irq_req                        level-sensitive interrupt request
//   pc, fetch_valid                fetch address and its valid flag
//   epc, irq_en, irq_ack, halted   saved return address, irq enable,
//                                  entry pulse, halt indication
//
// state | meaning
// BOOT  | single cycle after reset release, no fetch issued
// RUN   | fetching; redirects, interrupts and sequential advance
// HALT  | no fetch; waits for interrupt, jump or branch
module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] IRQ_VEC   = 16'h0004,
    parameter int          PC_STEP   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        reti,
    input  logic        halt,
    input  logic        irq_req,
    output logic [15:0] pc,
    output logic        fetch_valid,
    output logic [15:0] epc,
    output logic        irq_en,
    output logic        irq_ack,
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [15:0] STEP = 16'(PC_STEP);

    state_t      state, state_n;
    logic [15:0] pc_n, epc_n, pc_inc;
    logic        irq_en_n, irq_ack_n;
    logic        adv, irq_take;

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign adv         = fetch_valid && fetch_ready && !stall;
    assign irq_take    = irq_req && irq_en;
    assign pc_inc      = pc + STEP;   // wraps modulo 2^16

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        epc_n     = epc;
        irq_en_n  = irq_en;
        irq_ack_n = 1'b0;
        case (state)
            BOOT: state_n = RUN;
            RUN: begin
                if (jump) begin
                    pc_n = jump_target;
                end else if (branch_taken) begin
                    pc_n = branch_target;
                end else if (reti) begin
                    pc_n     = epc;
                    irq_en_n = 1'b1;
                end else if (irq_take && adv) begin
                    epc_n     = pc_inc;
                    pc_n      = IRQ_VEC;
                    irq_en_n  = 1'b0;
                    irq_ack_n = 1'b1;
                end else if (halt) begin
                    state_n = HALT;
                end else if (adv) begin
                    pc_n = pc_inc;
                end
            end
            HALT: begin
                if (jump) begin
                    pc_n    = jump_target;
                    state_n = RUN;
                end else if (branch_taken) begin
                    pc_n    = branch_target;
                    state_n = RUN;
                end else if (irq_take) begin
                    epc_n     = pc_inc;
                    pc_n      = IRQ_VEC;
                    irq_en_n  = 1'b0;
                    irq_ack_n = 1'b1;
                    state_n   = RUN;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // Bit 0 is cleared on every load so pc and epc stay halfword aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= BOOT;
            pc      <= {RESET_VEC[15:1], 1'b0};
            epc     <= 16'h0000;
            irq_en  <= 1'b0;
            irq_ack <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= {pc_n[15:1], 1'b0};
            epc     <= {epc_n[15:1], 1'b0};
            irq_en  <= irq_en_n;
            irq_ack <= irq_ack_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, fetch_ready, jump, branch_taken, reti, halt, irq_req;
    logic [15:0] jump_target, branch_target;
    logic [15:0] pc, epc;
    logic        fetch_valid, irq_en, irq_ack, halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
        .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .reti(reti), .halt(halt), .irq_req(irq_req),
        .pc(pc), .fetch_valid(fetch_valid), .epc(epc), .irq_en(irq_en),
        .irq_ack(irq_ack), .halted(halted)
    );

    typedef struct {
        logic        stall, fr, jmp;
        logic [15:0] jt;
        logic        br;
        logic [15:0] bt;
        logic        rti, hlt, irq;
        logic [15:0] e_pc;
        logic        e_fv;
        logic [15:0] e_epc;
        logic        e_ien, e_ack, e_hlt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic s, logic f, logic j, logic [15:0] jt, logic b,
                                logic [15:0] bt, logic r, logic h, logic i,
                                logic [15:0] epc_v, logic fv, logic [15:0] eepc,
                                logic ien, logic ack, logic hl);
        vec_t v;
        v.stall = s; v.fr = f; v.jmp = j; v.jt = jt; v.br = b; v.bt = bt;
        v.rti = r; v.hlt = h; v.irq = i;
        v.e_pc = epc_v; v.e_fv = fv; v.e_epc = eepc; v.e_ien = ien;
        v.e_ack = ack; v.e_hlt = hl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_fv,
                           input logic [15:0] e_epc, input logic e_ien,
                           input logic e_ack, input logic e_hlt);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".fetch_valid"}, 16'(fetch_valid), 16'(e_fv));
        chk({tag, ".epc"}, epc, e_epc);
        chk({tag, ".irq_en"}, 16'(irq_en), 16'(e_ien));
        chk({tag, ".irq_ack"}, 16'(irq_ack), 16'(e_ack));
        chk({tag, ".halted"}, 16'(halted), 16'(e_hlt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // stall fr jmp jt  br bt rti hlt irq | pc fv epc ien ack hlt
        // boot and sequential fetch
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0000,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0002,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0004,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0006,1,16'h0000,0,0,0));
        // stall holds, jump overrides stall, bit 0 cleared
        vecs.push_back(mk(0,1,1,16'h0010,0,16'h0,   0,0,0, 16'h0010,1,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0010,1,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0010,1,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0010,1,16'h0000,0,0,0));
        vecs.push_back(mk(1,1,1,16'h0101,0,16'h0,   0,0,0, 16'h0100,1,16'h0000,0,0,0));
        // jump beats branch; branch alone; no advance without fetch_ready
        vecs.push_back(mk(0,1,1,16'h0200,1,16'h0300,0,0,0, 16'h0200,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   1,16'h0305,0,0,0, 16'h0304,1,16'h0000,0,0,0));
        vecs.push_back(mk(0,0,0,16'h0,   0,16'h0,   0,0,0, 16'h0304,1,16'h0000,0,0,0));
        // reti enables interrupts, then irq entry at 0x0040
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   1,0,0, 16'h0000,1,16'h0000,1,0,0));
        vecs.push_back(mk(0,1,1,16'h0040,0,16'h0,   0,0,0, 16'h0040,1,16'h0000,1,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,1, 16'h0004,1,16'h0042,0,1,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,1, 16'h0006,1,16'h0042,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,1, 16'h0008,1,16'h0042,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   1,0,0, 16'h0042,1,16'h0042,1,0,0));
        // irq not taken without adv, nor alongside a jump
        vecs.push_back(mk(0,0,0,16'h0,   0,16'h0,   0,0,1, 16'h0042,1,16'h0042,1,0,0));
        vecs.push_back(mk(0,1,1,16'h0500,0,16'h0,   0,0,1, 16'h0500,1,16'h0042,1,0,0));
        // irq beats halt; halt is dropped
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,1,1, 16'h0004,1,16'h0502,0,1,0));
        // wrap-around
        vecs.push_back(mk(0,1,1,16'hFFFE,0,16'h0,   0,0,0, 16'hFFFE,1,16'h0502,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0000,1,16'h0502,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   1,0,0, 16'h0502,1,16'h0502,1,0,0));
        // halt at 0x0080, reti ignored while halted, irq exit
        vecs.push_back(mk(0,1,1,16'h0080,0,16'h0,   0,0,0, 16'h0080,1,16'h0502,1,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,1,0, 16'h0080,0,16'h0502,1,0,1));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0080,0,16'h0502,1,0,1));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   1,0,0, 16'h0080,0,16'h0502,1,0,1));
        vecs.push_back(mk(1,0,0,16'h0,   0,16'h0,   0,1,0, 16'h0080,0,16'h0502,1,0,1));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0080,0,16'h0502,1,0,1));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,1, 16'h0004,1,16'h0082,0,1,0));
        // halt again, exit by branch
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0006,1,16'h0082,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,1,0, 16'h0006,0,16'h0082,0,0,1));
        vecs.push_back(mk(0,1,0,16'h0,   1,16'h0701,0,0,0, 16'h0700,1,16'h0082,0,0,0));
        vecs.push_back(mk(0,1,0,16'h0,   0,16'h0,   0,0,0, 16'h0702,1,16'h0082,0,0,0));

        rst = 1'b1;
        stall = 0; fetch_ready = 0; jump = 0; branch_taken = 0; reti = 0;
        halt = 0; irq_req = 0; jump_target = 0; branch_target = 0;
        repeat (2) step();
        chk_all("reset", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        fetch_ready = 1'b1;
        #1;
        chk_all("boot", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall; fetch_ready = vecs[i].fr;
            jump = vecs[i].jmp; jump_target = vecs[i].jt;
            branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            reti = vecs[i].rti; halt = vecs[i].hlt; irq_req = vecs[i].irq;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_epc,
                    vecs[i].e_ien, vecs[i].e_ack, vecs[i].e_hlt);
        end

        // asynchronous reset mid-cycle while in RUN with a pending jump
        stall = 0; fetch_ready = 1; jump = 1; jump_target = 16'h1234;
        branch_taken = 0; reti = 0; halt = 0; irq_req = 0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        chk_all("rst_hold", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        jump = 0;
        rst = 1'b0;
        step();
        chk_all("rst_boot_exit", 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        chk("rst_advance.pc", pc, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
